// File: rtl/fp32_pkg.sv
// Shared FP32 constants and the divider FSM state encoding.
// Used by fp32_unpack and fp32_div_iter.
package fp32_pkg;

    localparam int          FP32_BIAS    = 127;
    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
    localparam logic [31:0] FP32_PINF    = 32'h7F800000;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } div_state_e;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational FP32 field split with zero/special flags; exponent 0 counts
// as zero, so denormals are flushed.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0] f,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [22:0] man,
    output logic        is_zero,
    output logic        is_special
);

    assign sign       = f[31];
    assign exp        = f[30:23];
    assign man        = f[22:0];
    assign is_zero    = (f[30:23] == 8'd0);
    assign is_special = (f[30:23] == FP32_EXP_MAX);

endmodule

// File: rtl/fp32_div_iter.sv
// Iterative FP32 divider: restoring radix-2, one quotient bit per falling edge.
// Build option FP32_DIV_ROUND_EN selects round-to-nearest-even instead of truncation.
module fp32_div_iter
    import fp32_pkg::*;
(
    input  logic        clkn_i,
    input  logic        rstn_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] Result
);

    logic        a_sign, b_sign, a_zero, b_zero, a_spec, b_spec;
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_man, b_man;

    fp32_unpack u_unpack_a (
        .f(A), .sign(a_sign), .exp(a_exp), .man(a_man),
        .is_zero(a_zero), .is_special(a_spec)
    );

    fp32_unpack u_unpack_b (
        .f(B), .sign(b_sign), .exp(b_exp), .man(b_man),
        .is_zero(b_zero), .is_special(b_spec)
    );

    div_state_e         state_q, state_d;
    logic [4:0]         step_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [24:0]        rem_q;
    logic [23:0]        dvsr_q;
    logic [25:0]        quo_q;
    logic [22:0]        mant_q;
    logic               nan_q, a_zero_q, b_zero_q;
`ifdef FP32_DIV_ROUND_EN
    logic               guard_q, sticky_q;
`endif

    logic               rem_ge;
    logic [24:0]        rem_sub;
    logic [23:0]        mant_rnd;
    logic signed [9:0]  exp_fin;
    logic [31:0]        packed_res;

    always_ff @(negedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        in_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_d = DIV;
            end
            DIV:     if (step_q == 5'd25) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    if (out_valid_o && out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Remainder stays below twice the divisor, so 25 bits are enough.
    assign rem_ge  = (rem_q >= {1'b0, dvsr_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, dvsr_q}) : rem_q;

    always_comb begin
        mant_rnd = {1'b0, mant_q};
`ifdef FP32_DIV_ROUND_EN
        if (guard_q && (sticky_q || mant_q[0])) mant_rnd = {1'b0, mant_q} + 24'd1;
`endif
        // A mantissa carry leaves the fraction at zero and bumps the exponent.
        exp_fin = exp_q + $signed({9'd0, mant_rnd[23]});

        if (nan_q)                   packed_res = FP32_QNAN;
        else if (a_zero_q)           packed_res = 32'h0000_0000;
        else if (b_zero_q)           packed_res = FP32_PINF | {sign_q, 31'd0};
        else if (exp_fin > 10'sd254) packed_res = FP32_PINF | {sign_q, 31'd0};
        else if (exp_fin < 10'sd1)   packed_res = 32'h0000_0000;
        else                         packed_res = {sign_q, exp_fin[7:0], mant_rnd[22:0]};
    end

    // NOTE: the datapath is reset along with the FSM so an aborted division
    // leaves no stale quotient or Result behind.
    always_ff @(negedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            step_q      <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            quo_q       <= '0;
            mant_q      <= '0;
            nan_q       <= 1'b0;
            a_zero_q    <= 1'b0;
            b_zero_q    <= 1'b0;
`ifdef FP32_DIV_ROUND_EN
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
`endif
            out_valid_o <= 1'b0;
            Result      <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid_i) begin
                    sign_q   <= a_sign ^ b_sign;
                    exp_q    <= {2'b00, a_exp} - {2'b00, b_exp} + 10'(FP32_BIAS);
                    rem_q    <= {2'b01, a_man};
                    dvsr_q   <= {1'b1, b_man};
                    quo_q    <= '0;
                    step_q   <= '0;
                    nan_q    <= a_spec | b_spec | (a_zero & b_zero);
                    a_zero_q <= a_zero;
                    b_zero_q <= b_zero;
                end
                DIV: begin
                    quo_q  <= {quo_q[24:0], rem_ge};
                    rem_q  <= rem_sub << 1;
                    step_q <= step_q + 5'd1;
                end
                NORM: begin
                    if (quo_q[25]) begin
                        mant_q   <= quo_q[24:2];
`ifdef FP32_DIV_ROUND_EN
                        guard_q  <= quo_q[1];
                        sticky_q <= quo_q[0] | (rem_q != '0);
`endif
                    end else begin
                        mant_q   <= quo_q[23:1];
                        exp_q    <= exp_q - 10'sd1;
`ifdef FP32_DIV_ROUND_EN
                        guard_q  <= quo_q[0];
                        sticky_q <= (rem_q != '0);
`endif
                    end
                end
                DONE: begin
                    // First DONE edge packs the result; later edges wait for the consumer.
                    if (!out_valid_o) begin
                        Result      <= packed_res;
                        out_valid_o <= 1'b1;
                    end else if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_div_iter.sv
// Directed self-checking bench for fp32_div_iter; expected quotients are hand-computed.
// Define FP32_DIV_ROUND_EN for both bench and RTL to check the rounding build.
module tb_fp32_div_iter;

    logic        clkn_i = 1'b1;
    logic        rstn_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] Result;

    int n_cmp  = 0;
    int n_fail = 0;

    fp32_div_iter dut (
        .clkn_i      (clkn_i),
        .rstn_i      (rstn_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .A           (A),
        .B           (B),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .Result      (Result)
    );

    always #5 clkn_i = ~clkn_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation: offer at a rising edge, accept on the next falling edge (edge 0),
    // then count falling edges until out_valid_o is seen, sampling on rising edges.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit disturb, input int hold,
                         input bit early_valid);
        int lat = -1;
        @(posedge clkn_i);
        check({tag, ".ready"}, 32'(in_ready_o), 32'd1);
        A = a; B = b; in_valid_i = 1'b1;
        @(negedge clkn_i);
        @(posedge clkn_i);
        in_valid_i = 1'b0;
        check({tag, ".busy"}, 32'(in_ready_o), 32'd0);
        for (int e = 1; e <= 40; e++) begin
            @(negedge clkn_i);
            @(posedge clkn_i);
            if (disturb && e == 10) begin
                A = $urandom; B = $urandom; in_valid_i = 1'b1;
            end
            if (out_valid_o) begin
                lat = e;
                break;
            end
        end
        in_valid_i = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'd28);
        check({tag, ".result"}, Result, exp_res);
        for (int h = 0; h < hold; h++) begin
            @(negedge clkn_i);
            @(posedge clkn_i);
            check({tag, ".bp_valid"}, 32'(out_valid_o), 32'd1);
            check({tag, ".bp_result"}, Result, exp_res);
            check({tag, ".bp_ready"}, 32'(in_ready_o), 32'd0);
        end
        out_ready_i = 1'b1;
        if (early_valid) begin
            A = 32'h3F80_0000; B = 32'h3F80_0000; in_valid_i = 1'b1;
        end
        @(negedge clkn_i);
        @(posedge clkn_i);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        check({tag, ".released"}, 32'(out_valid_o), 32'd0);
        check({tag, ".idle"}, 32'(in_ready_o), 32'd1);
        check({tag, ".held"}, Result, exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        rstn_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; A = '0; B = '0;
        #1;
        check("reset.valid", 32'(out_valid_o), 32'd0);
        check("reset.result", Result, 32'h0000_0000);
        check("reset.ready", 32'(in_ready_o), 32'd1);
        repeat (2) @(posedge clkn_i);
        rstn_i = 1'b1;

        do_op("six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 0, 1'b0);
`ifdef FP32_DIV_ROUND_EN
        do_op("one_div_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 0, 1'b0);
        do_op("two_div_three", 32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 1'b0, 0, 1'b0);
`else
        do_op("one_div_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 0, 1'b0);
        do_op("two_div_three", 32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAA, 1'b0, 0, 1'b0);
`endif
        do_op("nine_div_three", 32'h4110_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, 0, 1'b0);
        do_op("neg_six_div_two", 32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0, 0, 1'b0);
        do_op("neg_div_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, 0, 1'b0);
        do_op("pos_div_negzero", 32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, 1'b0, 0, 1'b0);
        do_op("zero_div_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 0, 1'b0);
        do_op("zero_div_two", 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0, 1'b0);
        do_op("denorm_flush", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 0, 1'b0);
        do_op("inf_operand", 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 0, 1'b0);
        do_op("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0, 0, 1'b0);
        do_op("exp_254_edge", 32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 1'b0, 0, 1'b0);
        do_op("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 0, 1'b0);
        do_op("exp_1_edge", 32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 1'b0, 0, 1'b0);
        do_op("backpressure", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 5, 1'b1);
        do_op("overlap", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b1, 0, 1'b0);

        // Abort at DIV step 10 while Result still holds the previous quotient.
        @(posedge clkn_i);
        A = 32'h4110_0000; B = 32'h4040_0000; in_valid_i = 1'b1;
        @(negedge clkn_i);
        @(posedge clkn_i);
        in_valid_i = 1'b0;
        repeat (10) @(negedge clkn_i);
        @(posedge clkn_i);
        rstn_i = 1'b0;
        #1;
        check("abort.valid", 32'(out_valid_o), 32'd0);
        check("abort.result", Result, 32'h0000_0000);
        check("abort.ready", 32'(in_ready_o), 32'd1);
        @(posedge clkn_i);
        rstn_i = 1'b1;
        seen = 0;
        repeat (35) begin
            @(negedge clkn_i);
            @(posedge clkn_i);
            if (out_valid_o) seen++;
        end
        check("abort.no_result", 32'(seen), 32'd0);
        do_op("after_abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_div_iter.md
FP32_DIV_ITER -- requirements
Module: fp32_div_iter

Interface
REQ-001 SHALL have ports: clkn_i  in  1  clock; all state updates on falling edge.
REQ-002 SHALL have: rstn_i  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have: in_valid_i  in  1  operand pair offered.
REQ-004 SHALL have: in_ready_o  out  1  divider can accept operands.
REQ-005 SHALL have: A  in  32  FP32 dividend.
REQ-006 SHALL have: B  in  32  FP32 divisor.
REQ-007 SHALL have: out_valid_o  out  1  Result holds a completed quotient.
REQ-008 SHALL have: out_ready_i  in  1  consumer takes Result.
REQ-009 SHALL have: Result  out  32  FP32 quotient A/B.
REQ-010 Reset scheme: one clock; reset is asynchronous and active-low.

Function
REQ-011 FSM states: IDLE, DIV, NORM, DONE; in_ready_o=1 only in IDLE.
REQ-012 IDLE: on in_valid_i&in_ready_o, register A/B, sign=A[31]^B[31], exp=A[30:23]-B[30:23]+127 (10-bit signed), remainder=1.A[22:0], step count=0; go DIV.
REQ-013 DIV: restoring radix-2 division, one quotient bit per cycle, 26 cycles: if rem>=1.B[22:0], bit=1 and rem-=divisor; rem<<=1.
REQ-014 NORM, one cycle: if q[25]=1, mantissa=q[24:2], exponent unchanged; else mantissa=q[23:1], exponent-1.
REQ-015 Fixed latency: out_valid_o rises on the 28th falling edge after the accept edge, for all operands including special cases.
REQ-016 DONE: Result and out_valid_o stable until out_ready_i=1; that edge returns to IDLE with out_valid_o=0.
REQ-017 No new operand is accepted in the DONE-to-IDLE edge; earliest next accept is the following edge.
REQ-018 An input with exponent 0 is treated as zero; denormals are flushed.
REQ-019 A=0, B nonzero -> 0x00000000 (+0).
REQ-020 B=0, A nonzero -> infinity with the computed sign (0x7F800000/0xFF800000).
REQ-021 Both zero, or either exponent 255 -> 0x7FC00000.
REQ-022 Final exponent >254 -> signed infinity; final exponent <1 -> 0x00000000.
REQ-023 in_valid_i outside IDLE is ignored; A/B changes after accept do not affect the result.

Reset
REQ-024 During reset: state=IDLE, in_ready_o=1 after release, out_valid_o=0, Result=0x00000000, all datapath registers 0.
REQ-025 Reset asserted in DIV/NORM/DONE aborts the operation; no Result is produced for it.

Configuration
REQ-026 With FP32_DIV_ROUND_EN defined: round-to-nearest-even using guard = the next quotient bit and sticky = OR of remaining q bits | (rem!=0).
REQ-027 With FP32_DIV_ROUND_EN defined: a mantissa carry-out increments the exponent and is checked against REQ-022.
REQ-028 Without FP32_DIV_ROUND_EN: truncate; the latency of REQ-015 is identical in both builds.

Structure
REQ-029 Shared package fp32_pkg SHALL hold: FP32_BIAS=127, FP32_EXP_MAX=8'hFF, FP32_QNAN=32'h7FC00000, FP32_PINF=32'h7F800000, and the FSM state enum.
REQ-030 One sub-module, fp32_unpack, SHALL be used: combinational sign/exp/mantissa split plus zero/special flags, shared with the multiplier path; everything else is inline.

Verification
REQ-031 A=0x40C00000, B=0x40000000 -> Result=0x40400000, out_valid_o at edge 28.
REQ-032 A=0x3F800000, B=0x40400000 -> 0x3EAAAAAA (truncate build); 0x3EAAAAAB (FP32_DIV_ROUND_EN build).
REQ-033 A=0xBF800000, B=0x00000000 -> 0xFF800000; A=0, B=0 -> 0x7FC00000; A=0, B=0x40000000 -> 0x00000000.
REQ-034 A=0x7F000000, B=0x3E800000 -> 0x7F800000; A=0x00800000, B=0x7F000000 -> 0x00000000.
REQ-035 Backpressure and overlap: hold out_ready_i=0 for 5 edges in DONE -> Result/out_valid_o unchanged and in_ready_o=0; toggle A/B mid-DIV -> result unaffected.
REQ-036 Reset mid-operation: assert rstn_i=0 at DIV step 10 -> out_valid_o=0 and Result=0 immediately; after release, a fresh 6/2 operation completes correctly.
